bcd_conv_sched: RTL and testbench

Round-robin scheduler that shares one iterative binary-to-BCD conversion engine between up to N_REQ requesters in the PWM display path, e.g. duty-cycle, frequency and setpoint readouts. It arbitrates requests, issues one conversion at a time to the engine over a start/done handshake, and returns each 3-digit BCD result to its owner. A watchdog returns an error result if the engine never completes.

---
 rtl/bcd_sched_pkg.sv | 24 ++
 rtl/bcd_conv_sched_rr_pick.sv | 36 +++
 rtl/bcd_conv_sched.sv | 203 ++++++++++++++++++++
 tb/tb_bcd_conv_sched.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_sched_pkg.sv
// ---------------------------------------------------------------------------
// bcd_sched_pkg
// Shared types and constants for the BCD conversion scheduler.
//   sched_state_e : scheduler FSM states
//   DEF_BIN_W     : default binary operand width
//   DEF_BCD_W     : default BCD result width (3 digits)
//   ERR_BCD       : result value returned when the engine times out
// ---------------------------------------------------------------------------
package bcd_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } sched_state_e;

    localparam int unsigned DEF_BIN_W = 8;
    localparam int unsigned DEF_BCD_W = 12;

    // Not a legal BCD pattern, so owners can spot it even without res_err.
    localparam logic [DEF_BCD_W-1:0] ERR_BCD = '1;

endpackage

// File: rtl/bcd_conv_sched_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches i_req upward starting at
// i_ptr+1, wrapping at N_REQ-1, and returns the first set index.
//   i_req    : request vector
//   i_ptr    : index of the previous winner (lowest priority this round)
//   o_winner : index of the chosen requester (0 when o_valid is low)
//   o_valid  : at least one request is set
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_winner,
    output logic             o_valid
);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_idx    = '0;
        // k runs 1..N_REQ so the previous winner is examined last.
        for (int k = 1; k <= int'(N_REQ); k++) begin
            w_idx = IDX_W'((int'(i_ptr) + k) % int'(N_REQ));
            if (!o_valid && i_req[w_idx]) begin
                o_valid  = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_sched.sv
// ---------------------------------------------------------------------------
// bcd_conv_sched
// Round-robin scheduler sharing one external binary-to-BCD engine between
// N_REQ requesters. One conversion is in flight at a time; a watchdog turns
// a silent engine into an error result after TIMEOUT cycles in WAIT.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req          : level request per requester
//   i_req_bin      : operands, requester i at [i*BIN_W +: BIN_W]
//   o_gnt          : one-hot pulse, operand captured
//   o_res_valid    : one-hot pulse, result for that requester
//   o_res_bcd      : shared result bus
//   o_res_err      : result is a timeout
//   o_eng_start    : start pulse to the engine
//   o_eng_bin      : engine operand, held until the next issue
//   i_eng_done     : engine completion pulse
//   i_eng_bcd      : engine result, valid with i_eng_done
//   o_busy         : scheduler not idle
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module bcd_conv_sched
    import bcd_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned BIN_W   = DEF_BIN_W,
    parameter int unsigned BCD_W   = DEF_BCD_W,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*BIN_W-1:0] i_req_bin,
    output logic [N_REQ-1:0]       o_gnt,
    output logic [N_REQ-1:0]       o_res_valid,
    output logic [BCD_W-1:0]       o_res_bcd,
    output logic                   o_res_err,
    output logic                   o_eng_start,
    output logic [BIN_W-1:0]       o_eng_bin,
    input  logic                   i_eng_done,
    input  logic [BCD_W-1:0]       i_eng_bcd,
    output logic                   o_busy
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    // BCD_W is three digits in every supported build.
    localparam logic [BCD_W-1:0] ERR_RES  = BCD_W'(ERR_BCD);

    // State and datapath registers
    sched_state_e     r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_win;
    logic [TMR_W-1:0] r_timer;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_res_valid;
    logic [BCD_W-1:0] r_res_bcd;
    logic             r_res_err;
    logic             r_eng_start;
    logic [BIN_W-1:0] r_eng_bin;
    logic             r_busy;

    // Next-state values
    sched_state_e     w_state_d;
    logic [IDX_W-1:0] w_ptr_d;
    logic [IDX_W-1:0] w_win_d;
    logic [TMR_W-1:0] w_timer_d;
    logic [N_REQ-1:0] w_gnt_d;
    logic [N_REQ-1:0] w_res_valid_d;
    logic [BCD_W-1:0] w_res_bcd_d;
    logic             w_res_err_d;
    logic             w_eng_start_d;
    logic [BIN_W-1:0] w_eng_bin_d;
    logic             w_busy_d;

    // Arbitration result
    logic [IDX_W-1:0] w_pick;
    logic             w_pick_valid;
    logic [BIN_W-1:0] w_pick_bin;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req    (i_req),
        .i_ptr    (r_ptr),
        .o_winner (w_pick),
        .o_valid  (w_pick_valid)
    );

    // Operand mux with constant slice bases.
    always_comb begin
        w_pick_bin = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (w_pick == IDX_W'(i)) begin
                w_pick_bin = i_req_bin[i*BIN_W +: BIN_W];
            end
        end
    end

    // Next-state and output logic
    always_comb begin
        w_state_d     = r_state;
        w_ptr_d       = r_ptr;
        w_win_d       = r_win;
        w_timer_d     = r_timer;
        w_gnt_d       = '0;
        w_res_valid_d = '0;
        w_res_bcd_d   = r_res_bcd;
        w_res_err_d   = r_res_err;
        w_eng_start_d = 1'b0;
        w_eng_bin_d   = r_eng_bin;

        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_win_d       = w_pick;
                    w_eng_bin_d   = w_pick_bin;
                    // Registered outputs: the ISSUE-cycle pulses are set on entry.
                    w_gnt_d       = ONE_HOT0 << w_pick;
                    w_eng_start_d = 1'b1;
                    w_state_d     = ISSUE;
                end
            end
            ISSUE: begin
                w_timer_d = '0;
                w_state_d = WAIT;
            end
            WAIT: begin
                if (i_eng_done) begin
                    w_res_bcd_d   = i_eng_bcd;
                    w_res_err_d   = 1'b0;
                    w_res_valid_d = ONE_HOT0 << r_win;
                    w_state_d     = DELIVER;
                end else if (r_timer == TMR_LAST) begin
                    w_res_bcd_d   = ERR_RES;
                    w_res_err_d   = 1'b1;
                    w_res_valid_d = ONE_HOT0 << r_win;
                    w_state_d     = DELIVER;
                end else begin
                    w_timer_d = r_timer + TMR_W'(1);
                end
            end
            DELIVER: begin
                // Winner drops to lowest priority for the next round.
                w_ptr_d   = r_win;
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        w_busy_d = (w_state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= IDX_W'(N_REQ - 1);
            r_win       <= '0;
            r_timer     <= '0;
            r_gnt       <= '0;
            r_res_valid <= '0;
            r_res_bcd   <= '0;
            r_res_err   <= 1'b0;
            r_eng_start <= 1'b0;
            r_eng_bin   <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_ptr       <= w_ptr_d;
            r_win       <= w_win_d;
            r_timer     <= w_timer_d;
            r_gnt       <= w_gnt_d;
            r_res_valid <= w_res_valid_d;
            r_res_bcd   <= w_res_bcd_d;
            r_res_err   <= w_res_err_d;
            r_eng_start <= w_eng_start_d;
            r_eng_bin   <= w_eng_bin_d;
            r_busy      <= w_busy_d;
        end
    end

    assign o_gnt       = r_gnt;
    assign o_res_valid = r_res_valid;
    assign o_res_bcd   = r_res_bcd;
    assign o_res_err   = r_res_err;
    assign o_eng_start = r_eng_start;
    assign o_eng_bin   = r_eng_bin;
    assign o_busy      = r_busy;

`ifndef SYNTHESIS
    a_gnt_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(o_gnt));
    a_res_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(o_res_valid));
    a_start_with_gnt: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_eng_start == (o_gnt != '0));
`endif

endmodule

// File: tb/tb_bcd_conv_sched.sv
module tb_bcd_conv_sched;

    localparam int N_REQ   = 4;
    localparam int BIN_W   = 8;
    localparam int BCD_W   = 12;
    localparam int TIMEOUT = 63;

    typedef struct {
        int         idx;
        logic [7:0] op;
    } gexp_t;

    typedef struct {
        int          idx;
        logic [11:0] bcd;
        logic        err;
    } rexp_t;

    typedef struct {
        int          idx;
        logic [7:0]  op;
        int          lat;
        logic [11:0] bcd;
    } vec_t;

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*BIN_W-1:0] req_bin;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       res_valid;
    logic [BCD_W-1:0]       res_bcd;
    logic                   res_err;
    logic                   eng_start;
    logic [BIN_W-1:0]       eng_bin;
    logic                   eng_done;
    logic [BCD_W-1:0]       eng_bcd;
    logic                   busy;

    logic model_done;
    logic inj_done;
    logic eng_en;
    int   eng_lat;

    assign eng_done = model_done | inj_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int gnt_cnt = 0;
    int rv_cnt  = 0;
    int gnt_times[$];
    int rv_times[$];
    gexp_t gq[$];
    rexp_t rq[$];

    bcd_conv_sched #(
        .N_REQ   (N_REQ),
        .BIN_W   (BIN_W),
        .BCD_W   (BCD_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_req_bin   (req_bin),
        .o_gnt       (gnt),
        .o_res_valid (res_valid),
        .o_res_bcd   (res_bcd),
        .o_res_err   (res_err),
        .o_eng_start (eng_start),
        .o_eng_bin   (eng_bin),
        .i_eng_done  (eng_done),
        .i_eng_bcd   (eng_bcd),
        .o_busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] to_bcd(input logic [7:0] b);
        int v;
        v = int'(b);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Engine model: done is sampled lat edges after the ISSUE edge (lat >= 1).
    initial begin
        int         lat;
        logic [7:0] op;
        model_done = 1'b0;
        eng_bcd    = '0;
        forever begin
            @(negedge clk);
            if (eng_start && eng_en) begin
                lat = eng_lat;
                op  = eng_bin;
                repeat (lat) @(negedge clk);
                model_done = 1'b1;
                eng_bcd    = to_bcd(op);
                @(negedge clk);
                model_done = 1'b0;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        gexp_t g;
        rexp_t r;
        forever begin
            @(negedge clk);
            if (gnt != '0) begin
                gnt_cnt++;
                gnt_times.push_back(cyc);
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", 32'(gnt), 32'(0));
                end else begin
                    g = gq.pop_front();
                    chk("gnt", 32'(gnt), 32'(1) << g.idx);
                    chk("eng_start", 32'(eng_start), 32'(1));
                    chk("eng_bin", 32'(eng_bin), 32'(g.op));
                end
            end else if (eng_start) begin
                chk("eng_start_without_gnt", 32'(eng_start), 32'(0));
            end
            if (res_valid != '0) begin
                rv_cnt++;
                rv_times.push_back(cyc);
                if (rq.size() == 0) begin
                    chk("res_valid_unexpected", 32'(res_valid), 32'(0));
                end else begin
                    r = rq.pop_front();
                    chk("res_valid", 32'(res_valid), 32'(1) << r.idx);
                    chk("res_bcd", 32'(res_bcd), 32'(r.bcd));
                    chk("res_err", 32'(res_err), 32'(r.err));
                end
            end
        end
    end

    task automatic push_g(input int idx, input logic [7:0] op);
        gexp_t g;
        g.idx = idx;
        g.op  = op;
        gq.push_back(g);
    endtask

    task automatic push_r(input int idx, input logic [11:0] bcd, input logic err);
        rexp_t r;
        r.idx = idx;
        r.bcd = bcd;
        r.err = err;
        rq.push_back(r);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt_count(input int target, input int budget);
        int ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (gnt_cnt >= target) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("gnt_wait", 32'(ok), 32'(1));
    endtask

    task automatic wait_rv_count(input int target, input int budget);
        int ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (rv_cnt >= target) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("res_valid_wait", 32'(ok), 32'(1));
    endtask

    // Returns #1 after the edge that raised gnt (i.e. inside ISSUE).
    task automatic wait_gnt_direct(input int budget);
        int ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (gnt != '0) begin
                ok = 1;
                break;
            end
        end
        chk("gnt_direct_wait", 32'(ok), 32'(1));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'(0));
        chk({tag, "_res_valid"}, 32'(res_valid), 32'(0));
        chk({tag, "_res_bcd"}, 32'(res_bcd), 32'(0));
        chk({tag, "_res_err"}, 32'(res_err), 32'(0));
        chk({tag, "_eng_start"}, 32'(eng_start), 32'(0));
        chk({tag, "_eng_bin"}, 32'(eng_bin), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
    endtask

    vec_t tbl[8];

    initial begin
        int b;
        int rb;
        int n;
        tbl[0] = '{idx: 0, op: 8'd255, lat: 20, bcd: 12'h255};
        tbl[1] = '{idx: 1, op: 8'd0,   lat: 1,  bcd: 12'h000};
        tbl[2] = '{idx: 2, op: 8'd99,  lat: 4,  bcd: 12'h099};
        tbl[3] = '{idx: 3, op: 8'd100, lat: 7,  bcd: 12'h100};
        tbl[4] = '{idx: 1, op: 8'd128, lat: 2,  bcd: 12'h128};
        tbl[5] = '{idx: 2, op: 8'd7,   lat: 3,  bcd: 12'h007};
        tbl[6] = '{idx: 0, op: 8'd200, lat: 5,  bcd: 12'h200};
        tbl[7] = '{idx: 3, op: 8'd63,  lat: 1,  bcd: 12'h063};

        rst_n    = 1'b1;
        req      = '0;
        req_bin  = '0;
        inj_done = 1'b0;
        eng_en   = 1'b1;
        eng_lat  = 1;
        #2 rst_n = 1'b0;
        cycles(3);
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);

        // Round robin from reset: req=1111 held
        eng_lat = 3;
        req_bin = {8'd40, 8'd30, 8'd20, 8'd10};
        push_g(0, 8'd10); push_g(1, 8'd20); push_g(2, 8'd30); push_g(3, 8'd40); push_g(0, 8'd10);
        push_r(0, 12'h010, 1'b0); push_r(1, 12'h020, 1'b0); push_r(2, 12'h030, 1'b0);
        push_r(3, 12'h040, 1'b0); push_r(0, 12'h010, 1'b0);
        req = 4'b1111;
        wait_gnt_count(5, 100);
        req = '0;
        wait_rv_count(5, 40);
        cycles(3);

        // Table-driven single requests
        for (int v = 0; v < 8; v++) begin
            eng_lat = tbl[v].lat;
            req_bin = $urandom;
            req_bin[tbl[v].idx*BIN_W +: BIN_W] = tbl[v].op;
            push_g(tbl[v].idx, tbl[v].op);
            push_r(tbl[v].idx, tbl[v].bcd, 1'b0);
            n = gnt_cnt + 1;
            b = rv_cnt + 1;
            req = 4'(1) << tbl[v].idx;
            wait_gnt_count(n, 10);
            req = '0;
            wait_rv_count(b, 60);
            cycles(1);
            chk("latency", 32'(rv_times[rv_times.size()-1] - gnt_times[gnt_times.size()-1]),
                32'(tbl[v].lat + 1));
            cycles(2);
        end

        // Zero-latency engine, req=0011 held (previous winner was 3)
        eng_lat = 1;
        req_bin = {8'd0, 8'd0, 8'd77, 8'd3};
        push_g(0, 8'd3); push_g(1, 8'd77); push_g(0, 8'd3);
        push_r(0, 12'h003, 1'b0); push_r(1, 12'h077, 1'b0); push_r(0, 12'h003, 1'b0);
        b  = gnt_times.size();
        rb = rv_times.size();
        n  = gnt_cnt + 3;
        req = 4'b0011;
        wait_gnt_count(n, 30);
        req = '0;
        wait_rv_count(rv_cnt + 1, 20);
        cycles(4);
        chk("b2b_gap0", 32'(gnt_times[b+1] - gnt_times[b]), 32'(4));
        chk("b2b_gap1", 32'(gnt_times[b+2] - gnt_times[b+1]), 32'(4));
        chk("min_latency", 32'(rv_times[rb] - gnt_times[b]), 32'(2));

        // Silent engine: done pulsed during ISSUE is ignored, then timeout
        eng_en  = 1'b0;
        req_bin = {8'd0, 8'd0, 8'd0, 8'd42};
        push_g(0, 8'd42);
        push_r(0, 12'hFFF, 1'b1);
        n   = rv_cnt + 1;
        req = 4'b0001;
        wait_gnt_direct(10);
        inj_done = 1'b1;
        req      = '0;
        cycles(1);
        inj_done = 1'b0;
        wait_rv_count(n, 100);
        cycles(1);
        chk("timeout_len", 32'(rv_times[rv_times.size()-1] - gnt_times[gnt_times.size()-1]),
            32'(TIMEOUT + 1));
        // Late done while idle
        cycles(2);
        n = rv_cnt;
        inj_done = 1'b1;
        cycles(1);
        inj_done = 1'b0;
        cycles(5);
        chk("late_done_no_res", 32'(rv_cnt), 32'(n));
        chk("late_done_idle", 32'(busy), 32'(0));

        // Reset mid-WAIT
        req_bin = {8'd0, 8'd0, 8'd0, 8'd5};
        push_g(0, 8'd5);
        n   = rv_cnt;
        req = 4'b0001;
        wait_gnt_direct(10);
        req = '0;
        cycles(5);
        chk("busy_in_wait", 32'(busy), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        chk("reset_hold_busy", 32'(busy), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cycles(3);
        chk("reset_no_res", 32'(rv_cnt), 32'(n));
        eng_en  = 1'b1;
        eng_lat = 2;
        req_bin = {8'd33, 8'd0, 8'd0, 8'd11};
        push_g(0, 8'd11); push_g(3, 8'd33);
        push_r(0, 12'h011, 1'b0); push_r(3, 12'h033, 1'b0);
        n   = gnt_cnt + 2;
        b   = rv_cnt + 2;
        req = 4'b1001;
        wait_gnt_count(n, 30);
        req = '0;
        wait_rv_count(b, 30);
        cycles(3);

        // req[2] only high while busy: never granted
        eng_lat = 5;
        req_bin = {8'd0, 8'd99, 8'd0, 8'd66};
        push_g(0, 8'd66);
        push_r(0, 12'h066, 1'b0);
        n   = gnt_cnt;
        b   = rv_cnt + 1;
        req = 4'b0001;
        wait_gnt_direct(10);
        req = 4'b0100;
        cycles(2);
        req = '0;
        wait_rv_count(b, 30);
        cycles(8);
        chk("dropped_req_gnts", 32'(gnt_cnt), 32'(n + 1));
        chk("dropped_req_res", 32'(rv_cnt), 32'(b));

        cycles(3);
        chk("gnt_queue_empty", 32'(gq.size()), 32'(0));
        chk("res_queue_empty", 32'(rq.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
